id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register with integrated load-use hazard detection for the pipelined MIPS core. It captures the control word produced by the decode-stage control unit together with register operands, immediate, PC+4 and register specifiers. It forwards them to the execute stage one cycle later. It detects load-use hazards against the instruction currently in EX, then stalls PC/IF-ID and injects a bubble, and it honours flush and global-stall requests.

## Interface
- DATA_WIDTH, 32, width of operand, immediate and PC paths
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high
- Stall  in  1  global hold from downstream; freezes this register and PC/IF-ID
- Flush  in  1  squash the ID instruction (taken branch/jump resolved); insert bubble
- RegDst_i[1:0], BranchEQ_i, BranchNE_i, MemRead_i, MemtoReg_i[1:0], MemWrite_i, ALUSrc_i, RegWrite_i, Jump_i[1:0], ALUOp_i[3:0]  in  16 total  decode control word
- ReadData1_i, ReadData2_i, Imm_i, PC4_i  in  DATA_WIDTH each  operands, sign-extended immediate, PC+4
- Rs_i, Rt_i, Rd_i, Shamt_i  in  5 each  register specifiers, shift amount
- Funct_i  in  6  function field
- *_o (same names, same widths as every *_i above)  out  registered copies for EX
- PCWrite  out  1  0 = hold PC
- IFIDWrite  out  1  0 = hold IF/ID register
- Bubble  out  1  1 = this edge loads a bubble (debug/trace)

## Operation
- Control word bit order, high to low: Jump, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp (16 bits).
- Hazard (combinational): Hazard = MemRead_o & (Rt_o != 0) & ((Rt_o == Rs_i) | (Rt_o == Rt_i)).
- Per-edge priority, highest first:
  - reset: all *_o, including data fields, load 0.
  - Stall: all *_o hold.
  - Flush: control word loads 0; data/specifier fields load inputs.
  - Hazard: control word loads 0; data fields load inputs.
  - Otherwise every *_o loads its *_i.
- Outputs:
  - PCWrite = IFIDWrite = ~(Stall | (Hazard & ~Flush)).
  - Bubble = ~reset & ~Stall & (Flush | Hazard).
- A load to $0 never raises Hazard.
- Flush with Hazard: Flush wins, so PC advances to the redirect target.
- A bubble clears MemRead_o, so Hazard deasserts next cycle; a load-use stall lasts exactly one cycle.
- Stall while Hazard: held state keeps Hazard asserted; the bubble is inserted on the first edge after Stall drops.

## Timing
- Latency: 1 cycle from *_i to *_o.
- PCWrite, IFIDWrite and Bubble are combinational from current inputs plus registered EX state. They are valid before the same edge they qualify. No combinational path exists from *_i control bits to *_o.
- Reset values: all *_o = 0. While reset is high, outputs follow inputs: PCWrite = IFIDWrite = 1 when Stall = 0 and Hazard = 0. Hazard evaluates false after the first reset edge.
- Reset mid-stall or mid-bubble: state clears on the reset edge with no residual stall.

## Configuration
- LOAD_USE_STALL_EN defined: hazard detection as above.
- LOAD_USE_STALL_EN undefined: Hazard is tied to 0, and only Stall and Flush affect PCWrite, IFIDWrite and Bubble. Software must schedule a nop after every load, with no hazard comparators synthesized.

## Test plan
- Reset: assert reset with arbitrary inputs for 1 edge -> all *_o = 0, Bubble = 0. Release with ADD control word 0x0107 -> *_o match inputs after 1 edge.
- Load-use: EX holds LW (MemRead_o = 1, Rt_o = 8), ID Rs_i = 8 -> PCWrite = IFIDWrite = 0, Bubble = 1. Next edge: control word = 0x0000, then PCWrite = 1 and the ADD is captured on the following edge.
- Load to $0: EX LW with Rt_o = 0, ID Rs_i = 0 -> no stall, PCWrite = 1.
- Flush plus hazard same cycle -> control word loads 0, PCWrite = IFIDWrite = 1, Bubble = 1.
- Stall held 3 cycles with changing inputs -> *_o unchanged, PCWrite = 0. On release the pending hazard bubble is inserted on the first free edge.
- LOAD_USE_STALL_EN undefined: repeat the load-use scenario -> no stall, ADD captured immediately with its control word intact.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decode-stage control word, operands and register
// specifiers going in, their registered EX-stage copies coming out, plus the
// stall/flush requests and the PC/IF-ID write enables.
// The master side is the decode/hazard environment; the slave side is the
// ID/EX register itself.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32
);

    // Pipeline control requests
    logic                  Stall;
    logic                  Flush;

    // Decode control word
    logic [1:0]            RegDst_i;
    logic                  BranchEQ_i;
    logic                  BranchNE_i;
    logic                  MemRead_i;
    logic [1:0]            MemtoReg_i;
    logic                  MemWrite_i;
    logic                  ALUSrc_i;
    logic                  RegWrite_i;
    logic [1:0]            Jump_i;
    logic [3:0]            ALUOp_i;

    // Decode operands and specifiers
    logic [DATA_WIDTH-1:0] ReadData1_i;
    logic [DATA_WIDTH-1:0] ReadData2_i;
    logic [DATA_WIDTH-1:0] Imm_i;
    logic [DATA_WIDTH-1:0] PC4_i;
    logic [4:0]            Rs_i;
    logic [4:0]            Rt_i;
    logic [4:0]            Rd_i;
    logic [4:0]            Shamt_i;
    logic [5:0]            Funct_i;

    // Execute-stage control word
    logic [1:0]            RegDst_o;
    logic                  BranchEQ_o;
    logic                  BranchNE_o;
    logic                  MemRead_o;
    logic [1:0]            MemtoReg_o;
    logic                  MemWrite_o;
    logic                  ALUSrc_o;
    logic                  RegWrite_o;
    logic [1:0]            Jump_o;
    logic [3:0]            ALUOp_o;

    // Execute-stage operands and specifiers
    logic [DATA_WIDTH-1:0] ReadData1_o;
    logic [DATA_WIDTH-1:0] ReadData2_o;
    logic [DATA_WIDTH-1:0] Imm_o;
    logic [DATA_WIDTH-1:0] PC4_o;
    logic [4:0]            Rs_o;
    logic [4:0]            Rt_o;
    logic [4:0]            Rd_o;
    logic [4:0]            Shamt_o;
    logic [5:0]            Funct_o;

    // Front-end write enables and trace
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  Bubble;

    modport master (
        output Stall, Flush,
        output RegDst_i, BranchEQ_i, BranchNE_i, MemRead_i, MemtoReg_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, Jump_i, ALUOp_i,
        output ReadData1_i, ReadData2_i, Imm_i, PC4_i,
               Rs_i, Rt_i, Rd_i, Shamt_i, Funct_i,
        input  RegDst_o, BranchEQ_o, BranchNE_o, MemRead_o, MemtoReg_o,
               MemWrite_o, ALUSrc_o, RegWrite_o, Jump_o, ALUOp_o,
        input  ReadData1_o, ReadData2_o, Imm_o, PC4_o,
               Rs_o, Rt_o, Rd_o, Shamt_o, Funct_o,
        input  PCWrite, IFIDWrite, Bubble
    );

    modport slave (
        input  Stall, Flush,
        input  RegDst_i, BranchEQ_i, BranchNE_i, MemRead_i, MemtoReg_i,
               MemWrite_i, ALUSrc_i, RegWrite_i, Jump_i, ALUOp_i,
        input  ReadData1_i, ReadData2_i, Imm_i, PC4_i,
               Rs_i, Rt_i, Rd_i, Shamt_i, Funct_i,
        output RegDst_o, BranchEQ_o, BranchNE_o, MemRead_o, MemtoReg_o,
               MemWrite_o, ALUSrc_o, RegWrite_o, Jump_o, ALUOp_o,
        output ReadData1_o, ReadData2_o, Imm_o, PC4_o,
               Rs_o, Rt_o, Rd_o, Shamt_o, Funct_o,
        output PCWrite, IFIDWrite, Bubble
    );

endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decode control word, operands and register specifiers and
// presents them to EX one cycle later. A load in EX whose destination is read
// by the instruction in ID holds PC and IF/ID for one cycle while a bubble
// (zero control word) is loaded here. Flush squashes the ID instruction and
// Stall freezes everything.
// Build option: define LOAD_USE_STALL_EN to include the load-use hazard
// comparators; without it the hazard is tied low and software must place a
// nop after every load.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    // Control word layout, high to low:
    // Jump[15:14] RegDst[13:12] ALUSrc[11] MemtoReg[10:9] RegWrite[8]
    // MemRead[7] MemWrite[6] BranchNE[5] BranchEQ[4] ALUOp[3:0]
    localparam int CTRL_W      = 16;
    localparam int MEMREAD_BIT = 7;

    logic [CTRL_W-1:0]     w_ctrlIn;
    logic                  w_hazard;
    logic                  w_squash;

    logic [CTRL_W-1:0]     r_ctrl;
    logic [DATA_WIDTH-1:0] r_ReadData1;
    logic [DATA_WIDTH-1:0] r_ReadData2;
    logic [DATA_WIDTH-1:0] r_Imm;
    logic [DATA_WIDTH-1:0] r_PC4;
    logic [4:0]            r_Rs;
    logic [4:0]            r_Rt;
    logic [4:0]            r_Rd;
    logic [4:0]            r_Shamt;
    logic [5:0]            r_Funct;

    assign w_ctrlIn = {bus.Jump_i, bus.RegDst_i, bus.ALUSrc_i, bus.MemtoReg_i,
                       bus.RegWrite_i, bus.MemRead_i, bus.MemWrite_i,
                       bus.BranchNE_i, bus.BranchEQ_i, bus.ALUOp_i};

`ifdef LOAD_USE_STALL_EN
    // A load in EX feeding either source of the ID instruction; $0 is never a real dependency
    always_comb begin
        w_hazard = r_ctrl[MEMREAD_BIT] & (r_Rt != 5'd0) &
                   ((r_Rt == bus.Rs_i) | (r_Rt == bus.Rt_i));
    end
`else
    // Load-use detection is left to the compiler's nop scheduling
    always_comb begin
        w_hazard = 1'b0;
    end
`endif

    // Either a flush or a load-use hazard turns the captured instruction into a bubble
    assign w_squash = bus.Flush | w_hazard;

    // Flush beats a hazard so the front end is free to fetch the redirect target
    assign bus.PCWrite   = ~(bus.Stall | (w_hazard & ~bus.Flush));
    assign bus.IFIDWrite = ~(bus.Stall | (w_hazard & ~bus.Flush));
    assign bus.Bubble    = ~reset & ~bus.Stall & w_squash;

    // Control word register: cleared by reset, frozen by stall, zeroed for a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (!bus.Stall) begin
            if (w_squash) begin
                r_ctrl <= '0;
            end else begin
                r_ctrl <= w_ctrlIn;
            end
        end
    end

    // Data and specifier registers: they still advance under a bubble, only stall freezes them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ReadData1 <= '0;
            r_ReadData2 <= '0;
            r_Imm       <= '0;
            r_PC4       <= '0;
            r_Rs        <= '0;
            r_Rt        <= '0;
            r_Rd        <= '0;
            r_Shamt     <= '0;
            r_Funct     <= '0;
        end else if (!bus.Stall) begin
            r_ReadData1 <= bus.ReadData1_i;
            r_ReadData2 <= bus.ReadData2_i;
            r_Imm       <= bus.Imm_i;
            r_PC4       <= bus.PC4_i;
            r_Rs        <= bus.Rs_i;
            r_Rt        <= bus.Rt_i;
            r_Rd        <= bus.Rd_i;
            r_Shamt     <= bus.Shamt_i;
            r_Funct     <= bus.Funct_i;
        end
    end

    assign {bus.Jump_o, bus.RegDst_o, bus.ALUSrc_o, bus.MemtoReg_o,
            bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o,
            bus.BranchNE_o, bus.BranchEQ_o, bus.ALUOp_o} = r_ctrl;

    assign bus.ReadData1_o = r_ReadData1;
    assign bus.ReadData2_o = r_ReadData2;
    assign bus.Imm_o       = r_Imm;
    assign bus.PC4_o       = r_PC4;
    assign bus.Rs_o        = r_Rs;
    assign bus.Rt_o        = r_Rt;
    assign bus.Rd_o        = r_Rd;
    assign bus.Shamt_o     = r_Shamt;
    assign bus.Funct_o     = r_Funct;

endmodule
